// File: rtl/cla_pkg.sv
// cla_pkg: shared FSM state type and slice width for the sequential borrow-lookahead subtractor
package cla_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/bla4_slice.sv
// bla4_slice: combinational 4-bit borrow-lookahead subtract slice
module bla4_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                bi,
  output logic [NIBBLE_W-1:0] d4,
  output logic                bo
);
  logic [NIBBLE_W-1:0] g, p;
  logic [NIBBLE_W:0]   br;
  assign g = ~a4 & b4;
  assign p = ~(a4 ^ b4);
  always_comb begin
    br[0] = bi;
    for (int i = 0; i < NIBBLE_W; i++) br[i+1] = g[i] | (p[i] & br[i]);
  end
  assign d4 = a4 ^ b4 ^ br[NIBBLE_W-1:0];
  assign bo = br[NIBBLE_W];
endmodule

// File: rtl/bla_sub_seq.sv
// bla_sub_seq: nibble-serial a - b - bin through one time-multiplexed borrow-lookahead slice
// Define BLA_SUB_OVF_EN to register signed overflow on ovf; otherwise ovf is tied low.
module bla_sub_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);
  localparam int NN = WIDTH / NIBBLE_W;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, d_q, d_d;
  logic br_q, br_d, bout_q, bout_d;
  logic [NIBBLE_W-1:0] d4;
  logic bo, last;
  bla4_slice u_slice (
    .a4(a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .b4(b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .bi(br_q),
    .d4(d4),
    .bo(bo)
  );
  assign last      = idx_q == IW'(NN - 1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign d         = d_q;
  assign bout      = bout_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    d_d     = d_q;
    br_d    = br_q;
    bout_d  = bout_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      b_d     = b;
      br_d    = bin;
      idx_d   = '0;
      state_d = CALC;
    end else if (state_q == CALC) begin
      r_d[idx_q*NIBBLE_W +: NIBBLE_W] = d4;
      br_d  = bo;
      idx_d = idx_q + 1'b1;
      if (last) begin
        state_d = DONE;
        d_d     = r_d;
        bout_d  = bo;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end
`ifdef BLA_SUB_OVF_EN
  logic ovf_q;
  // the MSB of the result comes straight from the slice on the final nibble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (state_q == CALC && last)
      ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ d4[NIBBLE_W-1]);
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_bla_sub_seq.sv
// tb_bla_sub_seq: scoreboard bench for bla_sub_seq against an arithmetic reference model
module tb_bla_sub_seq;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, bout, ovf;
  logic [W-1:0] d;
  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    time          t;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0, errors = 0;
  logic prev_ov = 1'b0;
  bla_sub_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, output exp_t e);
    longint u, s;
    u = longint'(x) - longint'(y) - longint'(c);
    s = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
    e.d    = W'(u);
    e.bout = u < 0;
`ifdef BLA_SUB_OVF_EN
    e.ovf  = (s > (longint'(1) <<< (W-1)) - 1) || (s < -(longint'(1) <<< (W-1)));
`else
    e.ovf  = 1'b0;
`endif
    e.t    = 0;
  endtask
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result d=%0h", d);
      end else begin
        me = q.pop_front();
        chk("d", d, me.d);
        chk("bout", bout, me.bout);
        chk("ovf", ovf, me.ovf);
        chk("latency", 32'(($time - me.t - 5) / 10), 4);
      end
    end
    prev_ov = out_valid;
  end
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit hold);
    exp_t e;
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin checks++; errors++; $display("FAIL idle_timeout in_ready=0 required=1"); end
    a = x; b = y; bin = c; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    model(x, y, c, e);
    e.t = $time;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
    if (!out_valid) begin checks++; errors++; $display("FAIL result_timeout out_valid=0 required=1"); end
    if (hold) begin
      repeat (5) begin
        in_valid = ~in_valid; a = W'($urandom); b = W'($urandom);
        @(negedge clk);
        chk("hold_d", d, e.d);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_out_valid", out_valid, 1);
      end
    end else begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_d_held", d, e.d);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d", d, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    op(16'h1234, 16'h0034, 1'b0, 0);
    op(16'h0000, 16'h0001, 1'b0, 0);
    op(16'h8000, 16'h0001, 1'b0, 0);
    op(16'h0005, 16'h0005, 1'b1, 0);
    op(16'hA5C3, 16'h1F2E, 1'b1, 1);
    @(negedge clk);
    a = 16'h1234; b = 16'h0034; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_d", d, 0);
    chk("abort_in_ready", in_ready, 1);
    q.delete();
    repeat (6) @(negedge clk);
    chk("abort_no_result", out_valid, 0);
    rst_n = 1'b1;
    op(16'h00FF, 16'h000F, 1'b0, 0);
    repeat (30) op(W'($urandom), W'($urandom), 1'($urandom), 0);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
